// File: rtl/phold_pkg.sv
// Shared types and constants for the PHOLD event engine.
package phold_pkg;

    typedef enum logic [2:0] {
        INIT,
        SCAN,
        MEM,
        PROC,
        GEN,
        DONE
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] ts;
        logic [7:0]  lp;
    } event_t;

    localparam logic [2:0]  MC_CMD_RD  = 3'd1;
    localparam logic [1:0]  MC_SIZE8   = 2'd3;

    // Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/phold_lfsr.sv
// 16-bit pseudo-random source used for new event timestamps and LP ids.
module phold_lfsr
    import phold_pkg::*;
(
    input  logic        clk,
    input  logic        i_reset,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (i_reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/phold_core.sv
// Sequential PHOLD engine: seeds an event queue, repeatedly services the
// minimum-timestamp event with MC reads and a fixed delay, stops at sim_end.
//
// state | meaning
// INIT  | seed queue, one entry per cycle
// SCAN  | linear min-ts search over the queue, updates GVT
// MEM   | issue/collect num_memcall reads on MC port 0
// PROC  | burn fixed_delay cycles
// GEN   | replace the serviced event with a future one
// DONE  | run finished, results frozen until reset
module phold_core
    import phold_pkg::*;
#(
    parameter int NUM_MC_PORTS    = 16,
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int QDEPTH          = 64
) (
    input  logic                                  clk,
    input  logic                                  i_reset,
    input  logic [15:0]                           sim_end,
    input  logic [47:0]                           addr,
    input  logic [8:0]                            num_init_events,
    input  logic [7:0]                            lp_mask,
    input  logic [3:0]                            num_memcall,
    input  logic [15:0]                           fixed_delay,
    input  logic [63:0]                           core_mask,
    output logic [15:0]                           gvt,
    output logic                                  rtn_vld,
    output logic                                  cleanup,
    output logic [NUM_MC_PORTS-1:0]               mc_rq_vld,
    output logic [NUM_MC_PORTS*3-1:0]             mc_rq_cmd,
    output logic [NUM_MC_PORTS*4-1:0]             mc_rq_scmd,
    output logic [NUM_MC_PORTS*48-1:0]            mc_rq_vadr,
    output logic [NUM_MC_PORTS*2-1:0]             mc_rq_size,
    output logic [NUM_MC_PORTS*MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    output logic [NUM_MC_PORTS*64-1:0]            mc_rq_data,
    output logic [NUM_MC_PORTS-1:0]               mc_rq_flush,
    input  logic [NUM_MC_PORTS-1:0]               mc_rq_stall,
    input  logic [NUM_MC_PORTS-1:0]               mc_rs_vld,
    input  logic [NUM_MC_PORTS*3-1:0]             mc_rs_cmd,
    input  logic [NUM_MC_PORTS*4-1:0]             mc_rs_scmd,
    input  logic [NUM_MC_PORTS*64-1:0]            mc_rs_data,
    input  logic [NUM_MC_PORTS*MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    output logic [NUM_MC_PORTS-1:0]               mc_rs_stall,
    output logic [63:0]                           total_cycles,
    output logic [63:0]                           total_stalls,
    output logic [63:0]                           total_events,
    output logic [63:0]                           total_antimsg,
    output logic [63:0]                           total_q_conf,
    output logic [63:0]                           avg_mem_time,
    output logic [63:0]                           avg_hist_time,
    output logic [63:0]                           avg_proc_time
);

    localparam int IW = $clog2(QDEPTH);
    localparam int CW = IW + 1;

    state_t          state, state_nxt;
    event_t          queue [QDEPTH];
    logic [15:0]     lfsr;
    logic [CW-1:0]   init_cnt, n_init;
    logic [IW-1:0]   scan_idx, best_idx, fin_idx, sel_idx;
    logic [15:0]     best_ts, fin_ts, sel_ts, gvt_q, proc_cnt;
    logic            best_found, fin_found, cand_take, scan_last;
    logic [7:0]      sel_lp;
    logic [3:0]      req_cnt, rsp_cnt, rsp_nxt;
    logic            rq_vld0, rq_acc, done_seen;
    logic            unused_ok;

    phold_lfsr u_lfsr (
        .clk     (clk),
        .i_reset (i_reset),
        .lfsr    (lfsr)
    );

    assign n_init    = (num_init_events > 9'(QDEPTH)) ? CW'(QDEPTH) : num_init_events[CW-1:0];
    assign scan_last = (scan_idx == IW'(QDEPTH - 1));
    assign rq_vld0   = (state == MEM) && (req_cnt < num_memcall);
    assign rq_acc    = rq_vld0 && !mc_rq_stall[0];
    assign rsp_nxt   = rsp_cnt + {3'd0, mc_rs_vld[0]};

    // The last scanned entry must be folded in combinationally to finish in QDEPTH cycles.
    always_comb begin
        cand_take = queue[scan_idx].valid && (!best_found || (queue[scan_idx].ts < best_ts));
        fin_found = best_found || queue[scan_idx].valid;
        fin_ts    = cand_take ? queue[scan_idx].ts : best_ts;
        fin_idx   = cand_take ? scan_idx : best_idx;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: begin
                if ((n_init == '0) || !core_mask[0]) begin
                    state_nxt = DONE;
                end else if (init_cnt == n_init - 1'b1) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (scan_last) begin
                    if (!fin_found || (fin_ts >= sim_end)) begin
                        state_nxt = DONE;
                    end else if (num_memcall != 4'd0) begin
                        state_nxt = MEM;
                    end else begin
                        state_nxt = (fixed_delay != 16'd0) ? PROC : GEN;
                    end
                end
            end
            MEM: begin
                if (rsp_nxt == num_memcall) begin
                    state_nxt = (fixed_delay != 16'd0) ? PROC : GEN;
                end
            end
            PROC: begin
                if (proc_cnt == 16'd0) begin
                    state_nxt = GEN;
                end
            end
            GEN:     state_nxt = SCAN;
            DONE:    state_nxt = DONE;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                queue[i] <= '0;
            end
            init_cnt      <= '0;
            scan_idx      <= '0;
            best_idx      <= '0;
            best_ts       <= '0;
            best_found    <= 1'b0;
            sel_idx       <= '0;
            sel_ts        <= '0;
            sel_lp        <= '0;
            gvt_q         <= '0;
            req_cnt       <= '0;
            rsp_cnt       <= '0;
            proc_cnt      <= '0;
            done_seen     <= 1'b0;
            total_cycles  <= '0;
            total_stalls  <= '0;
            total_events  <= '0;
            avg_mem_time  <= '0;
            avg_hist_time <= '0;
            avg_proc_time <= '0;
        end else begin
            done_seen <= (state == DONE);
            if (state != DONE) total_cycles <= total_cycles + 64'd1;
            if (rq_vld0 && mc_rq_stall[0]) total_stalls <= total_stalls + 64'd1;
            if (state == MEM)  avg_mem_time  <= avg_mem_time + 64'd1;
            if (state == SCAN) avg_hist_time <= avg_hist_time + 64'd1;
            if (state == PROC) avg_proc_time <= avg_proc_time + 64'd1;

            // Delay timer counts down to zero; loaded on any entry into PROC.
            if ((state_nxt == PROC) && (state != PROC)) begin
                proc_cnt <= fixed_delay - 16'd1;
            end else if (state == PROC) begin
                proc_cnt <= proc_cnt - 16'd1;
            end

            case (state)
                INIT: begin
                    if (state_nxt != DONE) begin
                        queue[init_cnt[IW-1:0]] <= event_t'{1'b1, 16'd0, 8'(init_cnt) & lp_mask};
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + 1'b1;
                    if (cand_take) begin
                        best_ts    <= queue[scan_idx].ts;
                        best_idx   <= scan_idx;
                        best_found <= 1'b1;
                    end
                    if (scan_last) begin
                        best_found <= 1'b0;
                        sel_idx    <= fin_idx;
                        sel_ts     <= fin_ts;
                        sel_lp     <= queue[fin_idx].lp;
                        req_cnt    <= '0;
                        rsp_cnt    <= '0;
                        if (fin_found) gvt_q <= fin_ts;
                    end
                end
                MEM: begin
                    if (rq_acc) req_cnt <= req_cnt + 4'd1;
                    rsp_cnt <= rsp_nxt;
                end
                GEN: begin
                    queue[sel_idx] <= event_t'{1'b1, sel_ts + 16'd1 + {12'd0, lfsr[3:0]},
                                               lfsr[15:8] & lp_mask};
                    total_events   <= total_events + 64'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mc_rq_vld    = '0;
        mc_rq_cmd    = '0;
        mc_rq_scmd   = '0;
        mc_rq_vadr   = '0;
        mc_rq_size   = '0;
        mc_rq_rtnctl = '0;
        mc_rq_data   = '0;
        mc_rq_flush  = '0;
        mc_rs_stall  = '0;
        mc_rq_vld[0] = rq_vld0;
        if (rq_vld0) begin
            mc_rq_cmd[2:0]                   = MC_CMD_RD;
            mc_rq_size[1:0]                  = MC_SIZE8;
            mc_rq_vadr[47:0]                 = addr + {37'd0, sel_lp, 3'b000};
            mc_rq_rtnctl[MC_RTNCTL_WIDTH-1:0] = MC_RTNCTL_WIDTH'(req_cnt);
        end
        rtn_vld = (state == DONE) && !done_seen;
        cleanup = (state == DONE);
    end

    assign gvt           = gvt_q;
    assign total_antimsg = '0;
    assign total_q_conf  = '0;

    assign unused_ok = ^{core_mask[63:1], mc_rq_stall[NUM_MC_PORTS-1:1],
                         mc_rs_vld[NUM_MC_PORTS-1:1], mc_rs_cmd, mc_rs_scmd,
                         mc_rs_data, mc_rs_rtnctl};

endmodule

// File: tb/tb_phold_core.sv
// Directed bench for phold_core with a zero-latency read responder on port 0.
module tb_phold_core;

    localparam int NP = 16;
    localparam int RW = 32;
    localparam logic [47:0] ADDR = 48'h1234_5678_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               i_reset;
    logic [15:0]        sim_end;
    logic [47:0]        addr;
    logic [8:0]         num_init_events;
    logic [7:0]         lp_mask;
    logic [3:0]         num_memcall;
    logic [15:0]        fixed_delay;
    logic [63:0]        core_mask;
    logic [15:0]        gvt;
    logic               rtn_vld, cleanup;
    logic [NP-1:0]      mc_rq_vld, mc_rq_flush, mc_rq_stall, mc_rs_vld, mc_rs_stall;
    logic [NP*3-1:0]    mc_rq_cmd, mc_rs_cmd;
    logic [NP*4-1:0]    mc_rq_scmd, mc_rs_scmd;
    logic [NP*48-1:0]   mc_rq_vadr;
    logic [NP*2-1:0]    mc_rq_size;
    logic [NP*RW-1:0]   mc_rq_rtnctl, mc_rs_rtnctl;
    logic [NP*64-1:0]   mc_rq_data, mc_rs_data;
    logic [63:0]        total_cycles, total_stalls, total_events, total_antimsg;
    logic [63:0]        total_q_conf, avg_mem_time, avg_hist_time, avg_proc_time;

    assign mc_rs_vld    = {{(NP-1){1'b0}}, mc_rq_vld[0] & ~mc_rq_stall[0]};
    assign mc_rs_cmd    = '0;
    assign mc_rs_scmd   = '0;
    assign mc_rs_data   = '0;
    assign mc_rs_rtnctl = mc_rq_rtnctl;

    phold_core #(.NUM_MC_PORTS(NP), .MC_RTNCTL_WIDTH(RW), .QDEPTH(64)) dut (
        .clk(clk), .i_reset(i_reset), .sim_end(sim_end), .addr(addr),
        .num_init_events(num_init_events), .lp_mask(lp_mask), .num_memcall(num_memcall),
        .fixed_delay(fixed_delay), .core_mask(core_mask), .gvt(gvt), .rtn_vld(rtn_vld),
        .cleanup(cleanup), .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd),
        .mc_rq_scmd(mc_rq_scmd), .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size),
        .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush),
        .mc_rq_stall(mc_rq_stall), .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd),
        .mc_rs_scmd(mc_rs_scmd), .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl),
        .mc_rs_stall(mc_rs_stall), .total_cycles(total_cycles), .total_stalls(total_stalls),
        .total_events(total_events), .total_antimsg(total_antimsg),
        .total_q_conf(total_q_conf), .avg_mem_time(avg_mem_time),
        .avg_hist_time(avg_hist_time), .avg_proc_time(avg_proc_time)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Bus monitor, sampled mid-cycle.
    int          rtn_cnt, acc_cnt, stall_cnt, vadr_bad, hold_bad, other_bad, cmd_bad;
    logic [47:0] first_vadr, last_vadr, prev_vadr;
    logic [31:0] last_rtnctl, prev_rtnctl;
    logic        prev_stalled;

    task automatic clear_mon();
        rtn_cnt = 0; acc_cnt = 0; stall_cnt = 0; vadr_bad = 0; hold_bad = 0;
        other_bad = 0; cmd_bad = 0; first_vadr = '0; last_vadr = '0;
        last_rtnctl = '0; prev_stalled = 1'b0; prev_vadr = '0; prev_rtnctl = '0;
    endtask

    always @(negedge clk) begin
        if (!i_reset) begin
            if (rtn_vld) rtn_cnt++;
            if (|mc_rq_vld[NP-1:1] || |mc_rq_flush || |mc_rs_stall) other_bad++;
            if (mc_rq_vld[0]) begin
                if (mc_rq_cmd[2:0] != 3'd1 || mc_rq_size[1:0] != 2'd3 || mc_rq_scmd[3:0] != 4'd0
                    || mc_rq_data[63:0] != 64'd0) cmd_bad++;
                if (mc_rq_vadr[47:0] < addr || mc_rq_vadr[47:0] > addr + 48'd24) vadr_bad++;
                if (prev_stalled && (mc_rq_vadr[47:0] != prev_vadr || mc_rq_rtnctl[31:0] != prev_rtnctl))
                    hold_bad++;
                if (mc_rq_stall[0]) begin
                    stall_cnt++;
                end else begin
                    if (acc_cnt == 0) first_vadr = mc_rq_vadr[47:0];
                    last_vadr   = mc_rq_vadr[47:0];
                    last_rtnctl = mc_rq_rtnctl[31:0];
                    acc_cnt++;
                end
            end
            prev_stalled = mc_rq_vld[0] && mc_rq_stall[0];
            prev_vadr    = mc_rq_vadr[47:0];
            prev_rtnctl  = mc_rq_rtnctl[31:0];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [8:0] n, input logic [15:0] se, input logic [7:0] msk,
                         input logic [3:0] nm, input logic [15:0] fd);
        i_reset = 1'b1;
        tick(); tick();
        num_init_events = n; sim_end = se; lp_mask = msk;
        num_memcall = nm; fixed_delay = fd; core_mask = 64'd1;
        clear_mon();
        i_reset = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag, output int waited);
        int n = 0;
        while (!cleanup && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, {63'd0, cleanup}, 64'd1);
        waited = n;
    endtask

    int w;

    initial begin
        i_reset = 1'b1; addr = ADDR; sim_end = 16'd0; num_init_events = 9'd0;
        lp_mask = 8'hFF; num_memcall = 4'd0; fixed_delay = 16'd0; core_mask = 64'd1;
        mc_rq_stall = '0;
        clear_mon();
        tick(); tick(); tick();
        check("rst_gvt", {48'd0, gvt}, 64'd0);
        check("rst_cleanup", {62'd0, cleanup, rtn_vld}, 64'd0);
        check("rst_rq_vld", {48'd0, mc_rq_vld}, 64'd0);
        check("rst_cycles", total_cycles, 64'd0);

        // No initial events: finishes straight out of INIT.
        start(9'd0, 16'd10, 8'hFF, 4'd1, 16'd0);
        wait_done(20, "n0", w);
        check("n0_latency_le2", {63'd0, w <= 2}, 64'd1);
        tick(); tick(); tick();
        check("n0_rtn_pulses", rtn_cnt, 64'd1);
        check("n0_gvt", {48'd0, gvt}, 64'd0);
        check("n0_events", total_events, 64'd0);
        check("n0_cycles", total_cycles, 64'd1);

        // Engine disabled by core_mask.
        start(9'd4, 16'd10, 8'hFF, 4'd1, 16'd0);
        core_mask = 64'hFFFF_FFFF_FFFF_FFFE;
        wait_done(20, "cm0", w);
        check("cm0_events", total_events, 64'd0);
        check("cm0_acc", acc_cnt, 64'd0);

        // sim_end = 0: first scan already reaches the end.
        start(9'd4, 16'd0, 8'hFF, 4'd1, 16'd0);
        wait_done(200, "se0", w);
        check("se0_gvt", {48'd0, gvt}, 64'd0);
        check("se0_events", total_events, 64'd0);
        check("se0_acc", acc_cnt, 64'd0);
        check("se0_cycles", total_cycles, 64'd68);
        check("se0_hist", avg_hist_time, 64'd64);

        // One event, two reads, three delay cycles.
        start(9'd1, 16'd1, 8'hFF, 4'd2, 16'd3);
        wait_done(400, "one", w);
        tick(); tick();
        check("one_acc", acc_cnt, 64'd2);
        check("one_vadr0", {16'd0, first_vadr}, {16'd0, ADDR});
        check("one_vadr1", {16'd0, last_vadr}, {16'd0, ADDR});
        check("one_rtnctl1", {32'd0, last_rtnctl}, 64'd1);
        check("one_cmd", cmd_bad, 64'd0);
        check("one_events", total_events, 64'd1);
        check("one_proc", avg_proc_time, 64'd3);
        check("one_mem", avg_mem_time, 64'd2);
        check("one_hist", avg_hist_time, 64'd128);
        check("one_cycles", total_cycles, 64'd135);
        check("one_stalls", total_stalls, 64'd0);
        check("one_gvt_range", {63'd0, gvt >= 16'd1 && gvt <= 16'd16}, 64'd1);
        check("one_rtn_pulses", rtn_cnt, 64'd1);
        check("one_other_ports", other_bad, 64'd0);
        check("one_zero_stats", total_antimsg | total_q_conf, 64'd0);

        // Same run with the first request stalled for five cycles.
        start(9'd1, 16'd1, 8'hFF, 4'd2, 16'd3);
        mc_rq_stall[0] = 1'b1;
        w = 0;
        while (!mc_rq_vld[0] && w < 200) begin tick(); w++; end
        check("stl_vld_seen", {63'd0, mc_rq_vld[0]}, 64'd1);
        repeat (5) tick();
        mc_rq_stall[0] = 1'b0;
        wait_done(400, "stl", w);
        check("stl_stalls", total_stalls, 64'd5);
        check("stl_mon_stalls", stall_cnt, 64'd5);
        check("stl_hold", hold_bad, 64'd0);
        check("stl_acc", acc_cnt, 64'd2);
        check("stl_mem", avg_mem_time, 64'd7);
        check("stl_cycles", total_cycles, 64'd140);
        check("stl_events", total_events, 64'd1);

        // Longer run over four LP ids.
        start(9'd8, 16'd100, 8'h03, 4'd1, 16'd0);
        wait_done(60000, "long", w);
        check("long_vadr_range", vadr_bad, 64'd0);
        check("long_gvt_ge100", {63'd0, gvt >= 16'd100}, 64'd1);
        check("long_events_pos", {63'd0, total_events > 64'd0}, 64'd1);
        check("long_acc_eq_events", acc_cnt, total_events);
        check("long_proc", avg_proc_time, 64'd0);
        repeat (10) tick();
        check("long_cleanup_held", {63'd0, cleanup}, 64'd1);
        check("long_rtn_pulses", rtn_cnt, 64'd1);
        check("long_other_ports", other_bad, 64'd0);

        // Reset in the middle of MEM, then a clean rerun.
        start(9'd1, 16'd1, 8'hFF, 4'd2, 16'd3);
        mc_rq_stall[0] = 1'b1;
        w = 0;
        while (!mc_rq_vld[0] && w < 200) begin tick(); w++; end
        check("mid_vld_seen", {63'd0, mc_rq_vld[0]}, 64'd1);
        tick();
        i_reset = 1'b1;
        tick();
        check("mid_rq_vld", {48'd0, mc_rq_vld}, 64'd0);
        check("mid_vadr", mc_rq_vadr[63:0], 64'd0);
        check("mid_cmd", {16'd0, mc_rq_cmd}, 64'd0);
        check("mid_stats", total_cycles | total_stalls | avg_mem_time | avg_hist_time, 64'd0);
        check("mid_done", {46'd0, gvt, cleanup, rtn_vld}, 64'd0);
        mc_rq_stall[0] = 1'b0;
        start(9'd1, 16'd1, 8'hFF, 4'd2, 16'd3);
        wait_done(400, "rerun", w);
        check("rerun_events", total_events, 64'd1);
        check("rerun_stalls", total_stalls, 64'd0);
        check("rerun_acc", acc_cnt, 64'd2);
        check("rerun_cycles", total_cycles, 64'd135);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/phold_core.md
Name: phold_core

Overview:
- Sequential discrete-event PHOLD benchmark engine inside the CAE personality.
- Seeds an event queue with `num_init_events` events and repeatedly processes the minimum-timestamp event.
- Each processed event issues `num_memcall` 8-byte reads on MC port 0, burns `fixed_delay` cycles, then is replaced by one new future event.
- Stops when GVT (the minimum pending timestamp) reaches `sim_end`, and reports GVT plus run statistics to the personality top.

Parameters:
- NUM_MC_PORTS, 16, number of MC ports; all buses are packed with port p at slice p.
- MC_RTNCTL_WIDTH, 32, rtnctl width per port.
- QDEPTH, 64, event queue entries.

Ports:
- clk  in  1  personality clock
- i_reset  in  1  synchronous active-high reset; top asserts it whenever the run is not enabled
- sim_end  in  16  end GVT
- addr  in  48  base of LP state array
- num_init_events  in  9  initial events; saturates at QDEPTH
- lp_mask  in  8  LP id mask
- num_memcall  in  4  reads per event
- fixed_delay  in  16  processing cycles per event
- core_mask  in  64  bit0 enables engine; others ignored
- gvt  out  16  final GVT
- rtn_vld  out  1  one-cycle done pulse
- cleanup  out  1  done level
- mc_rq_vld/cmd/scmd/vadr/size/rtnctl/data/flush  out  NUM_MC_PORTS x {1,3,4,48,2,RTNCTL,64,1}  requests
- mc_rq_stall  in  NUM_MC_PORTS  request backpressure
- mc_rs_vld/cmd/scmd/data/rtnctl  in  NUM_MC_PORTS x {1,3,4,64,RTNCTL}  responses
- mc_rs_stall  out  NUM_MC_PORTS  constant 0
- total_cycles, total_stalls, total_events, total_antimsg, total_q_conf, avg_mem_time, avg_hist_time, avg_proc_time  out  64 each  statistics

Behaviour:
- Reset: all outputs 0, queue empty, FSM in INIT.
- LFSR: 16-bit, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every cycle while not in reset.
- Queue entry: {valid, ts[15:0], lp[7:0]}.

FSM:
- INIT: one insert per cycle; entry i gets ts = 0, lp = i[7:0] & lp_mask. After N = min(num_init_events, QDEPTH) inserts go to SCAN. If N = 0 or core_mask[0] = 0, go to DONE with gvt 0.
- SCAN: linear scan, one entry per cycle, over QDEPTH entries; selects the valid entry with the smallest ts, lowest index on ties. GVT := that ts. If GVT >= sim_end, go to DONE with gvt = GVT. Otherwise go to MEM, or to PROC when num_memcall = 0.
- MEM: issue num_memcall reads on port 0 only.
  - cmd 3'd1, scmd 0, size 2'd3, vadr = addr + {lp, 3'b000}, rtnctl = request index, data 0.
  - A request is accepted when vld && !stall; it is held while stalled.
  - Count mc_rs_vld[0] responses; when responses == num_memcall, go to PROC.
- PROC: wait fixed_delay cycles (0 = no wait), then GEN.
- GEN: overwrite the selected entry with ts = old ts + 1 + LFSR[3:0] (16-bit wrap permitted) and lp = LFSR[15:8] & lp_mask. total_events += 1. Go to SCAN.
- DONE: rtn_vld = 1 for the entry cycle only; cleanup = 1 and gvt held until reset; no further MC requests.

Other ports:
- Ports 1..NUM_MC_PORTS-1: vld 0.
- mc_rq_flush 0.
- mc_rs_stall 0.

Statistics (frozen in DONE, cleared by reset):
- total_cycles: cycles outside reset before DONE.
- total_stalls: cycles with mc_rq_vld[0] && mc_rq_stall[0].
- total_antimsg and total_q_conf: always 0 (no rollback).
- avg_mem_time: cumulative MEM cycles.
- avg_proc_time: cumulative PROC cycles.
- avg_hist_time: cumulative SCAN cycles.
- The avg_* outputs are cumulative sums; the host divides them by total_events.

Boundary and mid-operation cases:
- Reset mid-operation aborts immediately.
- Outstanding responses arriving after reset are ignored.
- Responses are counted even when they arrive in the same cycle as a request is issued.

Decomposition:
- Package phold_pkg holds:
  - the FSM state enum {INIT, SCAN, MEM, PROC, GEN, DONE};
  - the event struct;
  - MC command constants (RD = 3'd1, SIZE8 = 2'd3);
  - the LFSR seed and taps.
- Sub-module phold_lfsr for the random generator.

Test Plan:
- num_init_events = 0 -> DONE about 2 cycles after reset release; rtn_vld pulses once; gvt = 0; total_events = 0.
- num_init_events = 4, sim_end = 0 -> first SCAN finds GVT 0 >= 0; gvt = 0; total_events = 0; no MC requests.
- num_init_events = 1, sim_end = 1, num_memcall = 2, fixed_delay = 3, zero-latency responder:
  - two reads at vadr = addr;
  - total_events = 1; avg_proc_time = 3;
  - gvt in 1..16.
- Same as above, but mc_rq_stall[0] held for 5 cycles -> request held stable; total_stalls = 5.
- num_init_events = 8, lp_mask = 8'h03, sim_end = 100 -> all vadr within addr..addr+24; final gvt >= 100; total_events > 0; cleanup stays 1.
- Reset asserted mid-MEM -> all outputs 0 the next cycle; the run restarts cleanly after release.
